// File: rtl/arithunit_arbiter_if.sv
// Bundles the requester, arithunit and response signals of arithunit_arbiter.
// master is the arbiter's view; slave is the view of the requesters, unit and consumer.
interface arithunit_arbiter_if #(
   parameter int NUM_REQ = 4,
   parameter int IDW     = 2
);
   logic [NUM_REQ-1:0]    req_valid;
   logic [NUM_REQ-1:0]    req_ready;
   logic [NUM_REQ*16-1:0] req_data_1;
   logic [NUM_REQ*16-1:0] req_data_2;
   logic [NUM_REQ*2-1:0]  req_op;

   logic [15:0]           au_data_1;
   logic [15:0]           au_data_2;
   logic [1:0]            au_op_sel;
   logic [15:0]           au_data_out;

   logic                  rsp_valid;
   logic                  rsp_ready;
   logic [IDW-1:0]        rsp_id;
   logic [15:0]           rsp_data;
   logic                  busy;

   modport master (
      input  req_valid, req_data_1, req_data_2, req_op, au_data_out, rsp_ready,
      output req_ready, au_data_1, au_data_2, au_op_sel, rsp_valid, rsp_id, rsp_data, busy
   );

   modport slave (
      output req_valid, req_data_1, req_data_2, req_op, au_data_out, rsp_ready,
      input  req_ready, au_data_1, au_data_2, au_op_sel, rsp_valid, rsp_id, rsp_data, busy
   );
endinterface

// File: rtl/arithunit_arbiter.sv
// Round-robin front end sharing one registered 16-bit arithunit among NUM_REQ
// requesters, with one operation in flight and a valid/ready result channel.
module arithunit_arbiter #(
   parameter int NUM_REQ       = 4,
   parameter int ARITH_LATENCY = 1,
   parameter int IDW           = 2
) (
   input  logic                clk,
   input  logic                reset,
   arithunit_arbiter_if.master bus
);
   localparam int DATA_W = 16;
   localparam int CNT_W  = (ARITH_LATENCY < 1) ? 1 : $clog2(ARITH_LATENCY + 1);

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      RESP
   } state_t;

   state_t              state;
   state_t              state_nxt;
   logic [IDW-1:0]      last_grant;
   logic [IDW-1:0]      grant_idx;
   logic                grant_any;
   logic [NUM_REQ-1:0]  grant_oh;
   logic [CNT_W-1:0]    cnt;
   logic                issue;
   logic                capture;
   logic                rsp_fire;

   logic [DATA_W-1:0]   au_data_1_q;
   logic [DATA_W-1:0]   au_data_2_q;
   logic [1:0]          au_op_q;
   logic                rsp_valid_q;
   logic [IDW-1:0]      rsp_id_q;
   logic [DATA_W-1:0]   rsp_data_q;

   // First valid requester strictly after 'last', wrapping; MSB flags a hit.
   function automatic logic [IDW:0] rr_pick(input logic [NUM_REQ-1:0] valid,
                                            input logic [IDW-1:0]     last);
      logic [IDW:0] pick;
      int           idx;
      pick = '0;
      for (int k = NUM_REQ; k >= 1; k--) begin
         idx = (int'(last) + k) % NUM_REQ;
         if (valid[idx]) pick = {1'b1, IDW'(idx)};
      end
      return pick;
   endfunction

   always_comb begin
      state_nxt = state;
      issue     = 1'b0;
      capture   = 1'b0;
      rsp_fire  = 1'b0;
      grant_oh  = '0;
      {grant_any, grant_idx} = rr_pick(bus.req_valid, last_grant);
      case (state)
         IDLE: begin
            if (grant_any) begin
               grant_oh[grant_idx] = 1'b1;
               issue               = 1'b1;
               state_nxt           = WAIT;
            end
         end
         WAIT: begin
            if (cnt == '0) begin
               capture   = 1'b1;
               state_nxt = RESP;
            end
         end
         RESP: begin
            if (bus.rsp_ready) begin
               rsp_fire  = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         last_grant  <= IDW'(NUM_REQ - 1);
         cnt         <= '0;
         au_data_1_q <= '0;
         au_data_2_q <= '0;
         au_op_q     <= '0;
         rsp_valid_q <= 1'b0;
         rsp_id_q    <= '0;
         rsp_data_q  <= '0;
      end else begin
         state <= state_nxt;
         // Issue stage: operands latched toward the unit, they stay put afterwards.
         if (issue) begin
            au_data_1_q <= bus.req_data_1[DATA_W*grant_idx +: DATA_W];
            au_data_2_q <= bus.req_data_2[DATA_W*grant_idx +: DATA_W];
            au_op_q     <= bus.req_op[2*grant_idx +: 2];
            last_grant  <= grant_idx;
            cnt         <= CNT_W'(ARITH_LATENCY);
         end else if (state == WAIT && cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
         end
         // Result stage: captured once, then held until the consumer takes it.
         if (capture) begin
            rsp_data_q  <= bus.au_data_out;
            rsp_id_q    <= last_grant;
            rsp_valid_q <= 1'b1;
         end else if (rsp_fire) begin
            rsp_valid_q <= 1'b0;
         end
      end
   end

   assign bus.req_ready = grant_oh;
   assign bus.au_data_1 = au_data_1_q;
   assign bus.au_data_2 = au_data_2_q;
   assign bus.au_op_sel = au_op_q;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_id    = rsp_id_q;
   assign bus.rsp_data  = rsp_data_q;
   assign bus.busy      = (state != IDLE);
endmodule
